// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores accept B/H/W only; loads additionally accept BU/HU.
    function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: extract/extend for loads, lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [31:0]       word_i,
    input  logic [HALF_W-1:0] wdata_i,
    output logic [31:0]       load_data_c_o,
    output logic [31:0]       merge_data_c_o
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        load_data_c_o = word_i;
        case (funct3_i)
            F3_B:    load_data_c_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_c_o = {24'd0, byte_sel};
            F3_H:    load_data_c_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_c_o = {16'd0, half_sel};
            default: load_data_c_o = word_i;
        endcase
    end

    // Replace only the addressed lane, keeping the rest of the word read back.
    always_comb begin
        merge_data_c_o = word_i;
        if (funct3_i == F3_B) begin
            case (addr_lo_i)
                2'd0: merge_data_c_o[7:0]   = wdata_i[7:0];
                2'd1: merge_data_c_o[15:8]  = wdata_i[7:0];
                2'd2: merge_data_c_o[23:16] = wdata_i[7:0];
                2'd3: merge_data_c_o[31:24] = wdata_i[7:0];
                default: merge_data_c_o = word_i;
            endcase
        end else if (funct3_i == F3_H) begin
            if (addr_lo_i[1]) merge_data_c_o[31:16] = wdata_i;
            else              merge_data_c_o[15:0]  = wdata_i;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between execute and a word-wide data memory without byte enables.
// Optional misalignment errors: define LSU_MISALIGN_CHECK_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    lsu_state_e              state_q, state_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              addr_lo_q, addr_lo_d;
    logic [HALF_W-1:0]       wdata_q, wdata_d;
    logic [DM_ADDRESS-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                    req_ready_q;

    logic [1:0]              req_lo_c;
    logic                    req_bad_c;
    logic [DATA_W-1:0]       load_data_c;
    logic [DATA_W-1:0]       merge_data_c;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^req_addr[ADDR_W-1:DM_ADDRESS+2];

    // Request classification: illegal funct3, and misalignment either flagged or masked.
    always_comb begin
        req_lo_c  = req_addr[1:0];
        req_bad_c = ~f3_legal(req_write, req_funct3);
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0])        req_bad_c = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_bad_c = 1'b1;
`else
        if (req_funct3[1:0] == 2'b01) req_lo_c = {req_addr[1], 1'b0};
        if (req_funct3[1:0] == 2'b10) req_lo_c = 2'b00;
`endif
    end

    lsu_align u_align (
        .funct3_i       (funct3_q),
        .addr_lo_i      (addr_lo_q),
        .word_i         (mem_rdata),
        .wdata_i        (wdata_q),
        .load_data_c_o  (load_data_c),
        .merge_data_c_o (merge_data_c)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d  = req_funct3;
                    addr_lo_d = req_lo_c;
                    wdata_d   = req_wdata[HALF_W-1:0];
                    if (req_bad_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        mem_addr_d = req_addr[DM_ADDRESS+1:2];
                        if (!req_write) begin
                            state_d    = LOAD;
                            mem_read_d = 1'b1;
                        end else if (req_funct3 == F3_W) begin
                            state_d     = STORE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d    = RMW_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            LOAD: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = load_data_c;
            end
            RMW_RD: begin
                state_d     = RMW_WR;
                mem_write_d = 1'b1;
                mem_wdata_d = merge_data_c;
            end
            STORE, RMW_WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= (state_d == IDLE);
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
